// File: rtl/vram_responder.sv
// -----------------------------------------------------------------------------
// vram_responder
//
// Single-port 2^ADDR_W x 8 video RAM shared between a display fetch engine and
// a CPU bus. The display always wins the port while vid_active is high. CPU
// writes are acknowledged as soon as they land in a small write buffer, which
// drains into the RAM one entry per cycle whenever the display is idle. CPU
// reads wait until the buffer is empty, so a read always observes every write
// that was acknowledged before it.
//
// Ports
//   vga_clk    : clock, all logic on the rising edge
//   reset_n    : synchronous active-low reset (RAM contents are retained)
//   vid_addr   : display read address
//   vid_active : display fetch window; display owns the RAM port while high
//   vid_data   : registered display read data (1-cycle latency, holds when idle)
//   cpu_req    : CPU request, held until cpu_ack
//   cpu_we     : 1 = write, 0 = read (stable while cpu_req is high)
//   cpu_addr   : CPU address (stable while cpu_req is high)
//   cpu_wdata  : CPU write data (stable while cpu_req is high)
//   cpu_ack    : one-cycle acknowledge pulse
//   cpu_rdata  : CPU read data, valid while cpu_ack is high, held otherwise
//
// Parameters
//   ADDR_W     : RAM address width
//   FIFO_DEPTH : write-buffer entries, power of two, at least 2
//   FONT_WP    : when 1, writes to addresses below 1024 are acked but dropped
// -----------------------------------------------------------------------------
module vram_responder #(
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int FONT_WP    = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_active,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata
);

  localparam int          IDX_W      = $clog2(FIFO_DEPTH);
  localparam int          PTR_W      = IDX_W + 1;
  localparam int          MEM_WORDS  = 2 ** ADDR_W;
  localparam logic [31:0] FONT_BYTES = 32'd1024;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } cpu_state_t;

  cpu_state_t state, state_next;

  logic [7:0]        mem [0:MEM_WORDS-1];
  logic [ADDR_W-1:0] fifo_addr [0:FIFO_DEPTH-1];
  logic [7:0]        fifo_data [0:FIFO_DEPTH-1];

  // One extra pointer bit tells a full buffer from an empty one when the
  // index bits are equal.
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             fifo_full, fifo_empty;

  logic font_hit;
  logic wr_accept;
  logic enqueue;
  logic rd_done;
  logic drain;

  assign wr_idx     = wr_ptr[IDX_W-1:0];
  assign rd_idx     = rd_ptr[IDX_W-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
  assign font_hit   = (FONT_WP != 0) && (32'(cpu_addr) < FONT_BYTES);

  // Next-state and per-cycle RAM port arbitration. At most one of the display
  // read, the CPU read completion and the buffer drain is active per cycle.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    wr_accept  = 1'b0;
    rd_done    = 1'b0;
    unique case (state)
      IDLE: begin
        // cpu_ack high means the current request was just served; ignoring
        // cpu_req in that cycle prevents accepting it twice.
        if (cpu_req && !cpu_ack) begin
          if (cpu_we) begin
            // Uses the registered full flag, so a drain in this same cycle
            // does not open a slot until the next cycle.
            wr_accept = !fifo_full;
          end else begin
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!cpu_req) begin
          state_next = IDLE;
        end else if (fifo_empty && !vid_active) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign enqueue = wr_accept && !font_hit;
  assign drain   = !vid_active && !rd_done && !fifo_empty;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_data  <= '0;
    end else begin
      cpu_ack <= wr_accept || rd_done;
      if (enqueue) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (vid_active) begin
        vid_data <= mem[vid_addr];
      end
      if (rd_done) begin
        cpu_rdata <= mem[cpu_addr];
      end
    end
  end

  // NOTE: storage arrays have no reset; clearing them would add a reset path
  // to every bit and block RAM inference. Empty/full come from the pointers.
  always_ff @(posedge vga_clk) begin
    if (reset_n && enqueue) begin
      fifo_addr[wr_idx] <= cpu_addr;
      fifo_data[wr_idx] <= cpu_wdata;
    end
  end

  // Writes are gated by reset_n so a reset edge never commits a buffered entry.
  always_ff @(posedge vga_clk) begin
    if (reset_n && drain) begin
      mem[fifo_addr[rd_idx]] <= fifo_data[rd_idx];
    end
  end

endmodule

// File: tb/tb_vram_responder.sv
// -----------------------------------------------------------------------------
// tb_vram_responder
//
// Self-checking bench for vram_responder (default parameters). The reference
// model is a flat byte array holding the architectural memory contents: an
// acknowledged non-font write updates it at once, and every CPU read must
// return it. Display reads are checked only after the write buffer has had
// time to drain, so the array also describes the physical RAM there.
// -----------------------------------------------------------------------------
module tb_vram_responder;

  localparam int ADDR_W     = 11;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 2 ** ADDR_W;

  logic              vga_clk;
  logic              reset_n;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_active;
  logic [7:0]        vid_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  vram_responder #(
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FONT_WP   (1)
  ) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .vid_addr  (vid_addr),
    .vid_active(vid_active),
    .vid_data  (vid_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata)
  );

  logic [7:0] ref_mem [0:MEM_WORDS-1];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       vid_rand = 1'b0;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge vga_clk);
    #1;
    if (vid_rand) begin
      vid_active = ($urandom_range(0, 1) == 1);
      vid_addr   = ADDR_W'($urandom);
    end
  endtask

  // Wait for cpu_ack with a cycle budget; lat = cycles to ack, -1 on timeout.
  task automatic wait_ack(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (cpu_ack) begin
        lat = i;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                           input int limit, output int lat);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    cpu_req   = 1'b1;
    wait_ack(limit, lat);
    if (lat > 0 && a >= ADDR_W'(1024)) ref_mem[a] = d;
    tick();
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input int limit,
                          output int lat, output logic [7:0] d);
    cpu_addr = a;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    wait_ack(limit, lat);
    d = cpu_rdata;
    tick();
  endtask

  // Display idle, no CPU traffic: lets the write buffer empty completely.
  task automatic settle();
    vid_rand   = 1'b0;
    vid_active = 1'b0;
    cpu_req    = 1'b0;
    repeat (FIFO_DEPTH + 3) tick();
  endtask

  initial begin
    int               lat;
    int               stall_acks;
    logic [7:0]       d;
    logic [7:0]       dv [0:4];
    logic [7:0]       saved [0:2];
    logic [ADDR_W-1:0] a;

    // Known RAM image so font-region reads have a defined expected value.
    for (int i = 0; i < MEM_WORDS; i++) begin
      ref_mem[i] = 8'($urandom);
      dut.mem[i] = ref_mem[i];
    end

    reset_n    = 1'b0;
    vid_addr   = '0;
    vid_active = 1'b0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    repeat (3) tick();
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_vid_data", 32'(vid_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic write then read of 1024.
    cpu_write(ADDR_W'(1024), 8'h41, 10, lat);
    check("wr1024_lat", 32'(lat), 32'd1);
    cpu_read(ADDR_W'(1024), 10, lat, d);
    check("rd1024_lat", 32'(lat), 32'd2);
    check("rd1024_data", 32'(d), 32'h41);

    // Font write-protect: acked, but RAM keeps its original byte.
    cpu_write(ADDR_W'(16), 8'hFF, 10, lat);
    check("font_wr_lat", 32'(lat), 32'd1);
    cpu_read(ADDR_W'(16), 10, lat, d);
    check("font_rd_data", 32'(d), 32'(ref_mem[16]));

    // Display sweep 1024..1031 with a CPU read held pending the whole time.
    for (int i = 0; i < 8; i++) begin
      cpu_write(ADDR_W'(1024 + i), 8'($urandom), 10, lat);
      check("sweep_prep_wr", 32'(lat), 32'd1);
    end
    settle();
    vid_active = 1'b1;
    vid_addr   = ADDR_W'(1024);
    cpu_addr   = ADDR_W'(1027);
    cpu_we     = 1'b0;
    cpu_req    = 1'b1;
    stall_acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("vid_sweep", 32'(vid_data), 32'(ref_mem[1024 + i]));
      if (cpu_ack) stall_acks++;
      vid_addr = ADDR_W'(1024 + i + 1);
    end
    check("vid_sweep_no_cpu_ack", 32'(stall_acks), 32'd0);
    // Drop the pending read and the window: no ack, vid_data holds.
    cpu_req    = 1'b0;
    vid_active = 1'b0;
    vid_addr   = ADDR_W'(1500);
    tick();
    tick();
    check("rd_abort_no_ack", 32'(cpu_ack), 32'd0);
    check("vid_hold", 32'(vid_data), 32'(ref_mem[1031]));

    // Buffer fills while the display owns the port; 5th write stalls.
    settle();
    vid_active = 1'b1;
    for (int i = 0; i < 5; i++) dv[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      cpu_write(ADDR_W'(1040 + i), dv[i], 10, lat);
      check("fill_wr_lat", 32'(lat), 32'd1);
    end
    cpu_addr   = ADDR_W'(1044);
    cpu_wdata  = dv[4];
    cpu_we     = 1'b1;
    cpu_req    = 1'b1;
    stall_acks = 0;
    repeat (12) begin
      tick();
      if (cpu_ack) stall_acks++;
    end
    check("full_stall", 32'(stall_acks), 32'd0);
    // First idle edge drains but the full flag still blocks; accept next edge.
    vid_active = 1'b0;
    wait_ack(10, lat);
    check("full_release_lat", 32'(lat), 32'd2);
    if (lat > 0) ref_mem[1044] = dv[4];
    tick();
    // Three entries left after the accept edge, one drained per edge: the
    // read completes on the third edge after it is sampled.
    cpu_read(ADDR_W'(1044), 20, lat, d);
    check("drain_rd_lat", 32'(lat), 32'd3);
    check("drain_rd_data", 32'(d), 32'(dv[4]));
    for (int i = 0; i < 4; i++) begin
      cpu_read(ADDR_W'(1040 + i), 10, lat, d);
      check("fill_rd_data", 32'(d), 32'(dv[i]));
    end

    // Read-after-write through the buffer to 1030.
    settle();
    vid_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dv[i] = 8'($urandom);
      cpu_write(ADDR_W'(1030), dv[i], 10, lat);
      check("raw_wr_lat", 32'(lat), 32'd1);
    end
    cpu_addr   = ADDR_W'(1030);
    cpu_we     = 1'b0;
    cpu_req    = 1'b1;
    stall_acks = 0;
    repeat (5) begin
      tick();
      if (cpu_ack) stall_acks++;
    end
    check("raw_rd_blocked", 32'(stall_acks), 32'd0);
    vid_active = 1'b0;
    wait_ack(20, lat);
    check("raw_rd_lat", 32'(lat), 32'd4);
    check("raw_rd_data", 32'(cpu_rdata), 32'(dv[2]));
    tick();

    // Randomized traffic with a randomly toggling display window.
    vid_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(0, 1023));
      else                           a = ADDR_W'(1024 + $urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        cpu_write(a, 8'($urandom), 200, lat);
        check("rand_wr_acked", 32'(lat > 0), 32'd1);
      end else begin
        cpu_read(a, 200, lat, d);
        check("rand_rd_lat_min", 32'(lat >= 2), 32'd1);
        check("rand_rd_data", 32'(d), 32'(ref_mem[a]));
      end
    end

    // Random display addresses once the buffer is empty.
    settle();
    vid_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a        = ADDR_W'($urandom);
      vid_addr = a;
      tick();
      check("rand_vid_data", 32'(vid_data), 32'(ref_mem[a]));
    end

    // Reset with three buffered writes and a read parked in RD_WAIT.
    settle();
    vid_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      saved[i] = ref_mem[1050 + i];
      cpu_write(ADDR_W'(1050 + i), saved[i] ^ 8'hA5, 10, lat);
      check("rst_prep_wr", 32'(lat), 32'd1);
    end
    cpu_addr = ADDR_W'(1050);
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    tick();
    reset_n    = 1'b0;
    vid_active = 1'b0;
    tick();
    check("midrst_ack", 32'(cpu_ack), 32'd0);
    check("midrst_rdata", 32'(cpu_rdata), 32'd0);
    check("midrst_vid_data", 32'(vid_data), 32'd0);
    tick();
    check("midrst_ack_hold", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    reset_n = 1'b1;
    tick();
    check("postrst_no_ack", 32'(cpu_ack), 32'd0);
    for (int i = 0; i < 3; i++) ref_mem[1050 + i] = saved[i];
    for (int i = 0; i < 3; i++) begin
      cpu_read(ADDR_W'(1050 + i), 10, lat, d);
      check("postrst_rd_lat", 32'(lat), 32'd2);
      check("postrst_rd_data", 32'(d), 32'(ref_mem[1050 + i]));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
